// File: rtl/trade_beep_sequencer_if.sv
// trade_beep_sequencer_if: trade requests in, beep gate and queue status out.
interface trade_beep_sequencer_if;
    logic       trade_valid;
    logic       enable;
    logic       trigger_signal;
    logic       busy;
    logic [3:0] pending_count;
    logic       dropped;
    modport master (output trade_valid, enable, input trigger_signal, busy, pending_count, dropped);
    modport slave  (input trade_valid, enable, output trigger_signal, busy, pending_count, dropped);
endinterface

// File: rtl/trade_beep_sequencer.sv
// trade_beep_sequencer: turns trade pulses into queued fixed-length beeps separated by silent gaps.
module trade_beep_sequencer #(
    parameter int unsigned BEEP_CYCLES = 5000000,
    parameter int unsigned GAP_CYCLES  = 2500000,
    parameter int unsigned MAX_PENDING = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    trade_beep_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BEEP, GAP} state_t;
    localparam logic [31:0] BEEP_LAST = 32'(BEEP_CYCLES - 1);
    localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);
    localparam logic [3:0]  PEND_MAX  = 4'(MAX_PENDING);
    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [3:0]  pend_q, pend_d;
    logic        dropped_q, dropped_d, trig_q, busy_q;
    logic        start, inc, full;
    always_comb begin
        full = pend_q == PEND_MAX;
        start = 1'b0;
        state_d = state_q;
        timer_d = timer_q + 32'd1;
        case (state_q)
            IDLE: begin
                start = (pend_q != 4'd0) || bus.trade_valid;
                timer_d = '0;
            end
            BEEP: if (timer_q == BEEP_LAST) begin
                state_d = GAP;
                timer_d = '0;
            end
            GAP: if (timer_q == GAP_LAST) begin
                start = pend_q != 4'd0;
                state_d = IDLE;
                timer_d = '0;
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
        if (start) begin
            state_d = BEEP;
            timer_d = '0;
        end
        // a full queue still accepts a pulse when a beep starts the same cycle
        inc = bus.trade_valid && (!full || start);
        pend_d = pend_q + {3'd0, inc} - {3'd0, start};
        dropped_d = bus.trade_valid && full && !start;
        if (!bus.enable) begin
            state_d = IDLE;
            timer_d = '0;
            pend_d = '0;
            dropped_d = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            pend_q <= '0;
            dropped_q <= 1'b0;
            trig_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q <= pend_d;
            dropped_q <= dropped_d;
            trig_q <= state_d == BEEP;
            busy_q <= state_d != IDLE;
        end
    end
    assign bus.trigger_signal = trig_q;
    assign bus.busy = busy_q;
    assign bus.pending_count = pend_q;
    assign bus.dropped = dropped_q;
endmodule

// File: tb/tb_trade_beep_sequencer.sv
// tb_trade_beep_sequencer: scoreboarded checks of the beep sequencer against a countdown reference model.
module tb_trade_beep_sequencer;
    localparam int BC = 4;
    localparam int GC = 2;
    localparam int MAXP = 15;
    localparam int SAT_BC = 24;

    logic clk, reset;
    trade_beep_sequencer_if bus ();
    trade_beep_sequencer_if bus_s ();

    trade_beep_sequencer #(.BEEP_CYCLES(BC), .GAP_CYCLES(GC), .MAX_PENDING(MAXP)) u_dut (
        .clk(clk), .reset(reset), .bus(bus.slave));
    trade_beep_sequencer #(.BEEP_CYCLES(SAT_BC), .GAP_CYCLES(GC), .MAX_PENDING(MAXP)) u_sat (
        .clk(clk), .reset(reset), .bus(bus_s.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [6:0] got, exp;
    logic [6:0] exp_q[$];

    // reference: 0 idle, 1 beep, 2 gap; m_left counts cycles remaining in the phase
    int m_state = 0;
    int m_left = 0;
    int m_pend = 0;

    task automatic model_step(input logic tv, input logic en, input logic rst);
        bit go, drp;
        go = 0;
        drp = 0;
        if (rst || !en) begin
            m_state = 0;
            m_left = 0;
            m_pend = 0;
        end else begin
            if (m_state == 0) go = (m_pend > 0) || tv;
            else if (m_left > 1) m_left--;
            else if (m_state == 1) begin
                m_state = 2;
                m_left = GC;
            end else begin
                go = m_pend > 0;
                m_state = 0;
            end
            if (tv) begin
                if (m_pend < MAXP || go) m_pend++;
                else drp = 1;
            end
            if (go) begin
                m_pend--;
                m_state = 1;
                m_left = BC;
            end
        end
        exp_q.push_back({m_state == 1, m_state != 0, 4'(m_pend), drp});
    endtask

    task automatic drive(input logic tv, input logic en, input logic rst);
        bus.trade_valid = tv;
        bus.enable = en;
        reset = rst;
        model_step(tv, en, rst);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(i[0], 1'b1, 1'b1);
            got = {bus.trigger_signal, bus.busy, bus.pending_count, bus.dropped};
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL reset cyc%0d got=%b exp=%b", i, got, exp);
            end
        end
        vectors++;
        if (got !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_zero got=%b exp=0000000", got);
        end
    endtask

    task automatic test_single();
        int trig_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            drive(i == 0, 1'b1, 1'b0);
            got = {bus.trigger_signal, bus.busy, bus.pending_count, bus.dropped};
            trig_cycles += int'(bus.trigger_signal);
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL single cyc%0d got=%b exp=%b", i, got, exp);
            end
        end
        vectors++;
        if (trig_cycles != BC) begin
            miscompares++;
            $display("FAIL single_len got=%0d exp=%0d", trig_cycles, BC);
        end
    endtask

    task automatic test_back_to_back();
        int beeps = 0;
        logic prev = 1'b0;
        for (int i = 0; i < 26; i++) begin
            drive(i < 3, 1'b1, 1'b0);
            got = {bus.trigger_signal, bus.busy, bus.pending_count, bus.dropped};
            beeps += int'(bus.trigger_signal && !prev);
            prev = bus.trigger_signal;
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL b2b cyc%0d got=%b exp=%b", i, got, exp);
            end
        end
        vectors++;
        if (beeps != 3 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_count got=%0d busy=%b exp=3 busy=0", beeps, bus.busy);
        end
    endtask

    task automatic test_gap_coincide();
        for (int i = 0; i < 24; i++) begin
            drive(i == 0 || i == 1 || i == 6, 1'b1, 1'b0);
            got = {bus.trigger_signal, bus.busy, bus.pending_count, bus.dropped};
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL gapco cyc%0d got=%b exp=%b", i, got, exp);
            end
            if (i == 6) begin
                vectors++;
                if (bus.pending_count !== 4'd1 || bus.dropped !== 1'b0 || bus.trigger_signal !== 1'b1) begin
                    miscompares++;
                    $display("FAIL gapco_edge got pend=%0d drop=%b trig=%b exp pend=1 drop=0 trig=1",
                             bus.pending_count, bus.dropped, bus.trigger_signal);
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        logic tv, en;
        int seen = 0;
        for (int i = 0; i < 28; i++) begin
            tv = (i < 4) || (i >= 5 && i < 10) || i == 18;
            en = !(i >= 4 && i < 10);
            drive(tv, en, 1'b0);
            got = {bus.trigger_signal, bus.busy, bus.pending_count, bus.dropped};
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL endrop cyc%0d got=%b exp=%b", i, got, exp);
            end
            if (i >= 4 && i < 18) seen += int'(bus.trigger_signal || bus.busy);
            if (i == 3) begin
                vectors++;
                if (bus.pending_count !== 4'd3) begin
                    miscompares++;
                    $display("FAIL endrop_pend got=%0d exp=3", bus.pending_count);
                end
            end
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL endrop_quiet got=%0d active cycles exp=0", seen);
        end
    endtask

    task automatic test_reset_mid_gap();
        int seen = 0;
        for (int i = 0; i < 18; i++) begin
            drive(i < 6, 1'b1, i == 6);
            got = {bus.trigger_signal, bus.busy, bus.pending_count, bus.dropped};
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL rstgap cyc%0d got=%b exp=%b", i, got, exp);
            end
            if (i == 5) begin
                vectors++;
                if (bus.pending_count !== 4'd5 || bus.trigger_signal !== 1'b0 || bus.busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rstgap_pre got pend=%0d trig=%b busy=%b exp pend=5 trig=0 busy=1",
                             bus.pending_count, bus.trigger_signal, bus.busy);
                end
            end
            if (i >= 6) seen += int'(got != 7'd0);
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL rstgap_quiet got=%0d nonzero cycles exp=0", seen);
        end
    endtask

    task automatic test_random();
        logic tv, en, rst;
        for (int i = 0; i < 300; i++) begin
            en = $urandom_range(0, 24) != 0;
            tv = $urandom_range(0, 2) == 0;
            rst = $urandom_range(0, 99) == 0;
            drive(tv, en, rst);
            got = {bus.trigger_signal, bus.busy, bus.pending_count, bus.dropped};
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL random cyc%0d got=%b exp=%b", i, got, exp);
            end
        end
    endtask

    task automatic test_saturation();
        int drops = 0, beeps = 0, cyc = 0;
        logic prev = 1'b0;
        bus_s.enable = 1'b1;
        for (int i = 0; i < 18; i++) begin
            bus_s.trade_valid = 1'b1;
            @(posedge clk);
            #1;
            drops += int'(bus_s.dropped);
            beeps += int'(bus_s.trigger_signal && !prev);
            prev = bus_s.trigger_signal;
        end
        bus_s.trade_valid = 1'b0;
        vectors++;
        if (bus_s.pending_count !== 4'd15) begin
            miscompares++;
            $display("FAIL sat_pend got=%0d exp=15", bus_s.pending_count);
        end
        while (bus_s.busy && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
            drops += int'(bus_s.dropped);
            beeps += int'(bus_s.trigger_signal && !prev);
            prev = bus_s.trigger_signal;
        end
        vectors++;
        if (cyc >= 1000) begin
            miscompares++;
            $display("FAIL sat_timeout got busy after %0d cycles exp idle", cyc);
        end
        vectors++;
        if (drops != 2) begin
            miscompares++;
            $display("FAIL sat_drops got=%0d exp=2", drops);
        end
        vectors++;
        if (beeps != 16) begin
            miscompares++;
            $display("FAIL sat_beeps got=%0d exp=16", beeps);
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.trade_valid = 1'b0;
        bus.enable = 1'b0;
        bus_s.trade_valid = 1'b0;
        bus_s.enable = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_gap_coincide();
        test_enable_drop();
        test_reset_mid_gap();
        test_random();
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, i == 0);
        exp_q.delete();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
